// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types, reset defaults and the instruction-length predicate
// so that fetch and decode always agree on which opcodes carry a 32-bit operand.
package cpu_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;

  localparam logic [7:0] OPC_LONG_01 = 8'h01;
  localparam logic [7:0] OPC_LONG_03 = 8'h03;
  localparam logic [7:0] OPC_LONG_08 = 8'h08;
  localparam logic [7:0] OPC_LONG_09 = 8'h09;
  localparam logic [7:0] OPC_LONG_0C = 8'h0C;
  localparam logic [7:0] OPC_LONG_0D = 8'h0D;
  localparam logic [7:0] OPC_LONG_1A = 8'h1A;
  localparam logic [7:0] OPC_LONG_1B = 8'h1B;
  localparam logic [7:0] OPC_LONG_1D = 8'h1D;
  localparam logic [7:0] OPC_LONG_1F = 8'h1F;
  localparam logic [7:0] OPC_LONG_20 = 8'h20;
  localparam logic [7:0] OPC_LONG_22 = 8'h22;
  localparam logic [7:0] OPC_LONG_24 = 8'h24;
  localparam logic [7:0] OPC_LONG_36 = 8'h36;
  localparam logic [7:0] OPC_LONG_37 = 8'h37;
  localparam logic [7:0] OPC_LONG_38 = 8'h38;
  localparam logic [7:0] OPC_LONG_39 = 8'h39;

  // One queue slot: the fetched halfword and the address it came from.
  typedef struct packed {
    logic [15:0] dat;
    logic [31:0] adr;
  } qent_t;

  function automatic logic is_long_opc(input logic [15:0] opc);
    logic res;
    res = 1'b0;
    if (!opc[15]) begin
      case (opc[15:8])
        OPC_LONG_01, OPC_LONG_03, OPC_LONG_08, OPC_LONG_09,
        OPC_LONG_0C, OPC_LONG_0D, OPC_LONG_1A, OPC_LONG_1B,
        OPC_LONG_1D, OPC_LONG_1F, OPC_LONG_20, OPC_LONG_22,
        OPC_LONG_24, OPC_LONG_36, OPC_LONG_37, OPC_LONG_38,
        OPC_LONG_39: res = 1'b1;
        default:     res = 1'b0;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu_fetch_queue.sv
// Circular halfword+address buffer: one push and zero to three pops per clock,
// with a synchronous clear and look-ahead on the three oldest entries.
module cpu_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  qent_t                   push_ent_i,
  input  logic [1:0]              pop_n_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output qent_t                   e0_o,
  output logic [15:0]             e1_dat_o,
  output logic [15:0]             e2_dat_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] idx1, idx2;
  logic [CNT_W-1:0] count_q, count_d;
  qent_t            mem_q [DEPTH];

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n_i);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_n_i);
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked purely by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) begin
      mem_q[wr_ptr_q] <= push_ent_i;
    end
  end

  always_comb begin
    idx1 = rd_ptr_q + PTR_W'(1);
    idx2 = rd_ptr_q + PTR_W'(2);
  end

  assign count_o  = count_q;
  assign e0_o     = mem_q[rd_ptr_q];
  assign e1_dat_o = mem_q[idx1].dat;
  assign e2_dat_o = mem_q[idx2].dat;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: keeps the halfword queue topped up from instruction
// memory and hands short/long instructions to decode, with stall and redirect.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_adr_o,
  output logic        imem_stb_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_dat_i,
  output logic [15:0] opcode_o,
  output logic [31:0] operand_o,
  output logic        valid_o,
  output logic [31:0] PC_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      redir_q, redir_d;
  logic             req_q, req_d;
  logic             drop_q, drop_d;
  logic [15:0]      opcode_q, opcode_d;
  logic [31:0]      operand_q, operand_d;
  logic [31:0]      pc_out_q, pc_out_d;
  logic             valid_q, valid_d;

  logic [31:0]      tgt;
  logic             acked, push, outstanding_next, head_long;
  logic [1:0]       pop_n;
  logic [CNT_W-1:0] q_count, count_next;
  qent_t            q_e0, push_ent;
  logic [15:0]      q_e1_dat, q_e2_dat;

  assign tgt       = branch_target_i & 32'hFFFF_FFFE;
  assign acked     = req_q & imem_ack_i;
  assign push      = acked & ~drop_q & ~branch_flag_i;
  assign push_ent  = '{dat: imem_dat_i, adr: pc_q};
  assign head_long = is_long_opc(q_e0.dat);

  cpu_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (branch_flag_i),
    .push_i     (push),
    .push_ent_i (push_ent),
    .pop_n_i    (pop_n),
    .count_o    (q_count),
    .e0_o       (q_e0),
    .e1_dat_o   (q_e1_dat),
    .e2_dat_o   (q_e2_dat)
  );

  // Issue side: flush beats stall, stall beats issue; a long head waits for its operand.
  always_comb begin
    opcode_d  = opcode_q;
    operand_d = operand_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    pop_n     = 2'd0;
    if (branch_flag_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d = 1'b0;
      if (head_long) begin
        if (q_count >= CNT_W'(3)) begin
          opcode_d  = q_e0.dat;
          operand_d = {q_e1_dat, q_e2_dat};
          pc_out_d  = q_e0.adr;
          valid_d   = 1'b1;
          pop_n     = 2'd3;
        end
      end else if (q_count >= CNT_W'(1)) begin
        opcode_d  = q_e0.dat;
        operand_d = 32'h0;
        pc_out_d  = q_e0.adr;
        valid_d   = 1'b1;
        pop_n     = 2'd1;
      end
    end
  end

  // Request side. A redirect that lands while a request is in flight parks the
  // target until that stale ack returns, so the address never moves under a strobe.
  always_comb begin
    pc_d    = pc_q;
    redir_d = redir_q;
    drop_d  = drop_q;
    if (acked) begin
      if (drop_q) begin
        pc_d   = redir_q;
        drop_d = 1'b0;
      end else begin
        pc_d = pc_q + 32'd2;
      end
    end
    if (branch_flag_i) begin
      if (req_q && !imem_ack_i) begin
        pc_d    = pc_q;
        drop_d  = 1'b1;
        redir_d = tgt;
      end else begin
        pc_d   = tgt;
        drop_d = 1'b0;
      end
    end

    count_next       = branch_flag_i ? '0 : (q_count + CNT_W'(push) - CNT_W'(pop_n));
    outstanding_next = req_q & ~imem_ack_i;
    req_d            = outstanding_next | (count_next < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      redir_q   <= RESET_PC;
      req_q     <= 1'b0;
      drop_q    <= 1'b0;
      opcode_q  <= 16'h0;
      operand_q <= 32'h0;
      pc_out_q  <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      redir_q   <= redir_d;
      req_q     <= req_d;
      drop_q    <= drop_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_adr_o = pc_q;
  assign imem_stb_o = req_q;
  assign opcode_o   = opcode_q;
  assign operand_o  = operand_q;
  assign valid_o    = valid_q;
  assign PC_o       = pc_out_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: a table of expected issues for a mixed program
// plus hand-written sequences for partial operands, stall, and redirects.
module tb_cpu_fetch;

  typedef struct {
    logic [15:0] opc;
    logic [31:0] opd;
    logic [31:0] pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_tgt = 32'h0;
  logic [31:0] imem_adr;
  logic        imem_stb;
  logic        imem_ack;
  logic [15:0] imem_dat = 16'h0;
  logic [15:0] opcode;
  logic [31:0] operand;
  logic        valid;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_budget = 1000000;
  int ack_count;

  logic [15:0] mem [logic [31:0]];

  cpu_fetch #(
    .DEPTH    (8),
    .RESET_PC (32'h0000_1000)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .branch_flag_i   (branch),
    .branch_target_i (branch_tgt),
    .imem_adr_o      (imem_adr),
    .imem_stb_o      (imem_stb),
    .imem_ack_i      (imem_ack),
    .imem_dat_i      (imem_dat),
    .opcode_o        (opcode),
    .operand_o       (operand),
    .valid_o         (valid),
    .PC_o            (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lookup(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0;
  endfunction

  // Zero-wait memory, throttled by ack_budget to create pending requests.
  assign imem_ack = imem_stb && (ack_count < ack_budget);

  always @(negedge clk) imem_dat <= lookup(imem_adr);

  always @(posedge clk or posedge rst) begin
    if (rst) ack_count <= 0;
    else if (imem_stb && imem_ack) ack_count <= ack_count + 1;
  end

  task automatic chk(input string nm, input logic [80:0] act, input logic [80:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_issue(input string nm, input vec_t e, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < budget);
    chk(nm, {valid, opcode, operand, pc}, {1'b1, e.opc, e.opd, e.pc});
  endtask

  task automatic apply_reset(input int budget);
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    branch = 1'b0;
    ack_budget = budget;
    #1;
    chk("rst_stb",     81'(imem_stb), 81'(0));
    chk("rst_adr",     81'(imem_adr), 81'(32'h1000));
    chk("rst_opcode",  81'(opcode),   81'(0));
    chk("rst_operand", 81'(operand),  81'(0));
    chk("rst_pc",      81'(pc),       81'(0));
    chk("rst_valid",   81'(valid),    81'(0));
    mem.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_pattern(input logic [31:0] base, input int n, input logic [15:0] pat);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(2 * i);
      mem[a] = pat | {4'h0, a[11:0]};
    end
  endtask

  function automatic vec_t mk(input logic [15:0] o, input logic [31:0] d, input logic [31:0] p);
    vec_t v;
    v.opc = o;
    v.opd = d;
    v.pc  = p;
    return v;
  endfunction

  initial begin
    vec_t        exp_tab [11];
    logic [15:0] prog [21];
    int          n;

    prog = '{16'h0110, 16'hDEAD, 16'hBEEF, 16'h0000, 16'h8123, 16'h0300, 16'h1234,
             16'h5678, 16'h0200, 16'h3900, 16'h0000, 16'h0001, 16'h3A00, 16'h1F7F,
             16'hCAFE, 16'hF00D, 16'h1E00, 16'h0900, 16'h0102, 16'h0304, 16'h0000};
    exp_tab[0]  = mk(16'h0110, 32'hDEAD_BEEF, 32'h1000);
    exp_tab[1]  = mk(16'h0000, 32'h0,         32'h1006);
    exp_tab[2]  = mk(16'h8123, 32'h0,         32'h1008);
    exp_tab[3]  = mk(16'h0300, 32'h1234_5678, 32'h100A);
    exp_tab[4]  = mk(16'h0200, 32'h0,         32'h1010);
    exp_tab[5]  = mk(16'h3900, 32'h0000_0001, 32'h1012);
    exp_tab[6]  = mk(16'h3A00, 32'h0,         32'h1018);
    exp_tab[7]  = mk(16'h1F7F, 32'hCAFE_F00D, 32'h101A);
    exp_tab[8]  = mk(16'h1E00, 32'h0,         32'h1020);
    exp_tab[9]  = mk(16'h0900, 32'h0102_0304, 32'h1022);
    exp_tab[10] = mk(16'h0000, 32'h0,         32'h1028);

    // NOP stream from all-zero memory: one issue per cycle once filled.
    apply_reset(1000000);
    release_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (!imem_stb && n < 8);
    chk("first_req", {48'h0, imem_stb, imem_adr}, {48'h0, 1'b1, 32'h1000});
    expect_issue("nop_0", mk(16'h0, 32'h0, 32'h1000), 10);
    for (int i = 1; i < 6; i++)
      expect_issue($sformatf("nop_%0d", i), mk(16'h0, 32'h0, 32'h1000 + 32'(2 * i)), 1);

    // Mixed short/long program.
    apply_reset(1000000);
    for (int i = 0; i < 21; i++) mem[32'h1000 + 32'(2 * i)] = prog[i];
    release_reset();
    for (int i = 0; i < 11; i++)
      expect_issue($sformatf("prog_%0d", i), exp_tab[i], 12);

    // Long instruction whose last operand halfword arrives late.
    apply_reset(2);
    mem[32'h1000] = 16'h0110;
    mem[32'h1002] = 16'hDEAD;
    mem[32'h1004] = 16'hBEEF;
    release_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (ack_count < 2 && n < 20);
    chk("partial_acks", 81'(ack_count), 81'(2));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("partial_bubble_%0d", i), 81'(valid), 81'(0));
    end
    ack_budget = 1000000;
    expect_issue("partial_issue", mk(16'h0110, 32'hDEAD_BEEF, 32'h1000), 4);

    // Stall mid-stream until the queue fills, then resume in order.
    apply_reset(1000000);
    fill_pattern(32'h1000, 64, 16'hA000);
    release_reset();
    expect_issue("stall_pre0", mk(16'hA000, 32'h0, 32'h1000), 10);
    expect_issue("stall_pre1", mk(16'hA002, 32'h0, 32'h1002), 1);
    stall = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", i), {valid, opcode, operand, pc},
          {1'b1, 16'hA002, 32'h0, 32'h1002});
    end
    chk("stall_stb_drop", 81'(imem_stb), 81'(0));
    stall = 1'b0;
    for (int i = 0; i < 4; i++)
      expect_issue($sformatf("stall_post%0d", i),
                   mk(16'hA004 + 16'(2 * i), 32'h0, 32'h1004 + 32'(2 * i)), 1);

    // Redirect while the 0x100A request is still waiting for its ack.
    apply_reset(5);
    fill_pattern(32'h1000, 16, 16'hA000);
    fill_pattern(32'h2000, 16, 16'hB000);
    release_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (!(ack_count == 5 && imem_stb) && n < 30);
    chk("flush_pending_adr", {48'h0, imem_stb, imem_adr}, {48'h0, 1'b1, 32'h100A});
    branch = 1'b1;
    branch_tgt = 32'h2001;
    @(negedge clk);
    branch = 1'b0;
    ack_budget = 1000000;
    chk("flush_valid_low", 81'(valid), 81'(0));
    n = 0;
    do begin @(negedge clk); n++; end while (!(imem_stb && imem_adr != 32'h100A) && n < 10);
    chk("flush_new_adr", {48'h0, imem_stb, imem_adr}, {48'h0, 1'b1, 32'h2000});
    expect_issue("flush_first", mk(16'hB000, 32'h0, 32'h2000), 10);
    expect_issue("flush_second", mk(16'hB002, 32'h0, 32'h2002), 1);

    // Redirect coinciding with stall and an ack.
    apply_reset(1000000);
    fill_pattern(32'h1000, 16, 16'hA000);
    fill_pattern(32'h3000, 16, 16'hC000);
    release_reset();
    expect_issue("fsa_pre0", mk(16'hA000, 32'h0, 32'h1000), 10);
    expect_issue("fsa_pre1", mk(16'hA002, 32'h0, 32'h1002), 1);
    chk("fsa_ack_coincident", 81'({imem_stb, imem_ack}), 81'(2'b11));
    stall = 1'b1;
    branch = 1'b1;
    branch_tgt = 32'h3000;
    @(negedge clk);
    stall = 1'b0;
    branch = 1'b0;
    chk("fsa_valid_low", 81'(valid), 81'(0));
    chk("fsa_new_adr", {48'h0, imem_stb, imem_adr}, {48'h0, 1'b1, 32'h3000});
    expect_issue("fsa_first", mk(16'hC000, 32'h0, 32'h3000), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
